// File: rtl/dct_pkg.sv
// Shared constants and types for the 2D DCT datapath.
package dct_pkg;

  localparam int unsigned DCT_N    = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SAMPLE_W = 18;

  typedef enum logic {StIdle, StRead} rd_state_e;

endpackage

// File: rtl/dct_transpose_bank.sv
// One 8x8 sample bank: whole-row synchronous write, whole-column combinational read.
module dct_transpose_bank
  import dct_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_W
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [IDX_W-1:0]                    row,
  input  logic [DCT_N-1:0][DATA_WIDTH-1:0]    wdata,
  input  logic [IDX_W-1:0]                    col,
  output logic [DCT_N-1:0][DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DCT_N][DCT_N];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int j = 0; j < DCT_N; j++) begin
        mem[row][j] <= wdata[j];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < DCT_N; i++) begin
      rdata[i] = mem[i][col];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: rows in, columns out, one bank filled while the other drains.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] d0,
  input  logic signed [DATA_WIDTH-1:0] d1,
  input  logic signed [DATA_WIDTH-1:0] d2,
  input  logic signed [DATA_WIDTH-1:0] d3,
  input  logic signed [DATA_WIDTH-1:0] d4,
  input  logic signed [DATA_WIDTH-1:0] d5,
  input  logic signed [DATA_WIDTH-1:0] d6,
  input  logic signed [DATA_WIDTH-1:0] d7,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] q0,
  output logic signed [DATA_WIDTH-1:0] q1,
  output logic signed [DATA_WIDTH-1:0] q2,
  output logic signed [DATA_WIDTH-1:0] q3,
  output logic signed [DATA_WIDTH-1:0] q4,
  output logic signed [DATA_WIDTH-1:0] q5,
  output logic signed [DATA_WIDTH-1:0] q6,
  output logic signed [DATA_WIDTH-1:0] q7,
  output logic [IDX_W-1:0]             col_idx,
  output logic                         first_col,
  output logic                         last_col
);

  logic [DCT_N-1:0][DATA_WIDTH-1:0] wdata;
  logic [DCT_N-1:0][DATA_WIDTH-1:0] rdata0, rdata1, rd_data, q_q;
  logic [IDX_W-1:0]                 wr_row, rd_col;
  logic                             wr_bank, rd_bank, blk_done;
  rd_state_e                        state;

  assign wdata    = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign blk_done = valid_in && !rst && (wr_row == IDX_W'(DCT_N - 1));
  assign rd_data  = rd_bank ? rdata1 : rdata0;

  dct_transpose_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
    .clk   (clk),
    .we    (valid_in && !rst && !wr_bank),
    .row   (wr_row),
    .wdata (wdata),
    .col   (rd_col),
    .rdata (rdata0)
  );

  dct_transpose_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
    .clk   (clk),
    .we    (valid_in && !rst && wr_bank),
    .row   (wr_row),
    .wdata (wdata),
    .col   (rd_col),
    .rdata (rdata1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_row  <= '0;
      wr_bank <= 1'b0;
    end else if (valid_in) begin
      wr_row <= wr_row + 1'b1;
      if (blk_done) wr_bank <= ~wr_bank;
    end
  end

  // Back-to-back blocks land exactly on rd_col == 7, so the read restarts without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      rd_col    <= '0;
      rd_bank   <= 1'b0;
      valid_out <= 1'b0;
      first_col <= 1'b0;
      last_col  <= 1'b0;
      col_idx   <= '0;
      q_q       <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          valid_out <= 1'b0;
          first_col <= 1'b0;
          last_col  <= 1'b0;
          if (blk_done) begin
            state   <= StRead;
            rd_bank <= wr_bank;
            rd_col  <= '0;
          end
        end
        StRead: begin
          valid_out <= 1'b1;
          q_q       <= rd_data;
          col_idx   <= rd_col;
          first_col <= (rd_col == '0);
          last_col  <= (rd_col == IDX_W'(DCT_N - 1));
          rd_col    <= rd_col + 1'b1;
          if (rd_col == IDX_W'(DCT_N - 1)) begin
            if (blk_done) rd_bank <= wr_bank;
            else          state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign q0 = q_q[0];
  assign q1 = q_q[1];
  assign q2 = q_q[2];
  assign q3 = q_q[3];
  assign q4 = q_q[4];
  assign q5 = q_q[5];
  assign q6 = q_q[6];
  assign q7 = q_q[7];

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer: directed table, corner sequences and random traffic vs a block model.
module tb_dct_transpose_buffer;

  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic signed [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic signed [DW-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic valid_out, first_col, last_col;
  logic [2:0] col_idx;

  logic signed [DW-1:0] din [8];
  logic signed [DW-1:0] qv [8];

  always #5 clk = ~clk;

  assign d0 = din[0];
  assign d1 = din[1];
  assign d2 = din[2];
  assign d3 = din[3];
  assign d4 = din[4];
  assign d5 = din[5];
  assign d6 = din[6];
  assign d7 = din[7];
  assign qv[0] = q0;
  assign qv[1] = q1;
  assign qv[2] = q2;
  assign qv[3] = q3;
  assign qv[4] = q4;
  assign qv[5] = q5;
  assign qv[6] = q6;
  assign qv[7] = q7;

  dct_transpose_buffer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .d5        (d5),
    .d6        (d6),
    .d7        (d7),
    .valid_out (valid_out),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .q4        (q4),
    .q5        (q5),
    .q6        (q6),
    .q7        (q7),
    .col_idx   (col_idx),
    .first_col (first_col),
    .last_col  (last_col)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Block-level model: a completed block schedules its 8 columns at fixed future edges.
  typedef struct {
    int e;
    int c;
    int q [8];
  } col_t;

  col_t expq [$];
  int   blk [8][8];
  int   m_row = 0;
  int   last_q [8];
  int   last_col_m = 0;
  bit   exp_v = 1'b0;
  int   edge_n = 0;

  task automatic tick(input bit r, input bit v);
    col_t ent;
    rst      = r;
    valid_in = v;
    @(posedge clk);
    if (r) begin
      expq.delete();
      m_row = 0;
      for (int i = 0; i < 8; i++) last_q[i] = 0;
      last_col_m = 0;
      exp_v = 1'b0;
    end else begin
      if (v) begin
        for (int j = 0; j < 8; j++) blk[m_row][j] = int'(din[j]);
        m_row++;
        if (m_row == 8) begin
          m_row = 0;
          for (int c = 0; c < 8; c++) begin
            ent.e = edge_n + 1 + c;
            ent.c = c;
            for (int i = 0; i < 8; i++) ent.q[i] = blk[i][c];
            expq.push_back(ent);
          end
        end
      end
      exp_v = 1'b0;
      if (expq.size() > 0 && expq[0].e == edge_n) begin
        ent = expq.pop_front();
        exp_v = 1'b1;
        last_col_m = ent.c;
        for (int i = 0; i < 8; i++) last_q[i] = ent.q[i];
      end
    end
    edge_n++;
    #1;
    check("valid_out", int'(valid_out), int'(exp_v));
    check("first_col", int'(first_col), int'(exp_v && last_col_m == 0));
    check("last_col", int'(last_col), int'(exp_v && last_col_m == 7));
    check("col_idx", int'(col_idx), last_col_m);
    for (int i = 0; i < 8; i++) check($sformatf("q%0d", i), int'(qv[i]), last_q[i]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
  endtask

  typedef struct {
    bit vin;
    int r;
    bit ev;
    int ec;
    int eq0;
    int eq7;
  } vec_t;

  vec_t tbl [18];

  initial begin
    for (int j = 0; j < 8; j++) din[j] = '0;

    for (int i = 0; i < 18; i++) begin
      if (i < 8)       tbl[i] = '{vin: 1'b1, r: i, ev: 1'b0, ec: 0, eq0: 0, eq7: 0};
      else if (i < 16) tbl[i] = '{vin: 1'b0, r: 0, ev: 1'b1, ec: i - 8, eq0: i - 8, eq7: 70 + i - 8};
      else             tbl[i] = '{vin: 1'b0, r: 0, ev: 1'b0, ec: 7, eq0: 7, eq7: 77};
    end

    // Reset with random activity on the inputs.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) din[j] = DW'($urandom);
      tick(1'b1, 1'($urandom));
    end

    // Single block, d_j = 10*r + j.
    for (int i = 0; i < 18; i++) begin
      for (int j = 0; j < 8; j++) din[j] = DW'(10 * tbl[i].r + j);
      tick(1'b0, tbl[i].vin);
      check("tbl_valid", int'(valid_out), int'(tbl[i].ev));
      check("tbl_col", int'(col_idx), tbl[i].ec);
      check("tbl_q0", int'(q0), tbl[i].eq0);
      check("tbl_q7", int'(q7), tbl[i].eq7);
    end

    // Signed extremes.
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 8; j++) din[j] = (r % 2 == 0) ? DW'(-131072) : DW'(131071);
      tick(1'b0, 1'b1);
    end
    idle(10);

    // Four back-to-back blocks.
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 8; r++) begin
        for (int j = 0; j < 8; j++) din[j] = DW'(1000 * k + 10 * r + j);
        tick(1'b0, 1'b1);
      end
    end
    idle(10);

    // Gapped input.
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 8; j++) din[j] = DW'(-(10 * r + j));
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
    end
    idle(10);

    // Reset after a partial block, then a full block.
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 8; j++) din[j] = DW'(500 + 10 * r + j);
      tick(1'b0, 1'b1);
    end
    tick(1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 8; j++) din[j] = DW'(2000 + 10 * r + j);
      tick(1'b0, 1'b1);
    end
    idle(12);

    // Reset during a column read.
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 8; j++) din[j] = DW'(3000 + 10 * r + j);
      tick(1'b0, 1'b1);
    end
    idle(3);
    tick(1'b1, 1'b0);
    check("rst_read_valid", int'(valid_out), 0);
    check("rst_read_q3", int'(q3), 0);
    idle(10);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      for (int j = 0; j < 8; j++) din[j] = DW'($urandom);
      tick($urandom_range(0, 99) == 0, ($urandom % 4) != 0);
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
